// File: rtl/digit_serial_adder_pkg.sv
// digit_serial_adder_pkg: shared state encoding and digit size for the digit-serial adder
package dld_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RUN  = 2'b01,
        DONE = 2'b10
    } state_t;
    localparam int DIGIT = 2;
endpackage

// File: rtl/digit_serial_adder_if.sv
// digit_serial_adder_if: request/result bundle between a requester and the digit-serial adder
interface digit_serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             cin;
    logic             busy;
    logic             done;
    logic             cout;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] sum;
    modport master (output start, a, b, cin, input busy, done, sum, cout);
    modport slave (input start, a, b, cin, output busy, done, sum, cout);
endinterface

// File: rtl/digit_serial_adder_sc_ass_mux.sv
// sc_ass_mux: 2-bit adder slice; both carry-in outcomes are formed and the real carry selects one
module sc_ass_mux (
    input  logic aa1,
    input  logic aa0,
    input  logic bb1,
    input  logic bb0,
    input  logic cc0,
    output logic cc1,
    output logic ss1,
    output logic ss0
);
    logic [2:0] w_sum_c0;
    logic [2:0] w_sum_c1;
    assign w_sum_c0 = {1'b0, aa1, aa0} + {1'b0, bb1, bb0};
    assign w_sum_c1 = w_sum_c0 + 3'd1;
    assign {cc1, ss1, ss0} = cc0 ? w_sum_c1 : w_sum_c0;
endmodule

// File: rtl/digit_serial_adder.sv
// digit_serial_adder: WIDTH-bit adder that streams two bits per cycle through one sc_ass_mux slice,
// recirculating the slice carry and collecting the sum LSB pair first.
module digit_serial_adder
    import dld_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input logic                 clk,
    input logic                 rst_n,
    digit_serial_adder_if.slave bus
);
    localparam int STEPS = WIDTH / DIGIT;
    localparam int CW    = $clog2(STEPS) + 1;

    if ((WIDTH % DIGIT) != 0 || WIDTH < DIGIT) begin : g_bad_width
        $error("digit_serial_adder: WIDTH must be even and >= 2");
    end

    state_t           r_state;
    state_t           w_next;
    logic [WIDTH-1:0] r_op_a;
    logic [WIDTH-1:0] r_op_b;
    logic [WIDTH-1:0] r_acc;
    logic [WIDTH-1:0] r_sum;
    logic [WIDTH-1:0] w_acc_next;
    logic [CW-1:0]    r_cnt;
    logic             r_carry;
    logic             r_cout;
    logic             w_cc1;
    logic             w_ss1;
    logic             w_ss0;
    logic             w_last;
    logic             w_accept;

    sc_ass_mux u_slice (
        .aa1(r_op_a[1]),
        .aa0(r_op_a[0]),
        .bb1(r_op_b[1]),
        .bb0(r_op_b[0]),
        .cc0(r_carry),
        .cc1(w_cc1),
        .ss1(w_ss1),
        .ss0(w_ss0)
    );

    // New sum digits enter at the top so the LSB pair ends up at bit 0 after the last step
    if (WIDTH == DIGIT) begin : g_acc_narrow
        assign w_acc_next = {w_ss1, w_ss0};
    end else begin : g_acc_wide
        assign w_acc_next = {w_ss1, w_ss0, r_acc[WIDTH-1:DIGIT]};
    end

    assign w_last   = r_cnt == CW'(STEPS - 1);
    assign w_accept = bus.start && (r_state != RUN);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= IDLE;
        else        r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        w_next = (r_state == RUN) ? (w_last ? DONE : RUN) : (bus.start ? RUN : IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_op_a  <= '0;
            r_op_b  <= '0;
            r_acc   <= '0;
            r_sum   <= '0;
            r_cnt   <= '0;
            r_carry <= 1'b0;
            r_cout  <= 1'b0;
        end else if (w_accept) begin
            r_op_a  <= bus.a;
            r_op_b  <= bus.b;
            r_carry <= bus.cin;
            r_cnt   <= '0;
        end else if (r_state == RUN) begin
            r_op_a  <= r_op_a >> DIGIT;
            r_op_b  <= r_op_b >> DIGIT;
            r_carry <= w_cc1;
            r_acc   <= w_acc_next;
            r_cnt   <= r_cnt + CW'(1);
            if (w_last) begin
                r_sum  <= w_acc_next;
                r_cout <= w_cc1;
            end
        end
    end

    assign bus.busy = r_state == RUN;
    assign bus.done = r_state == DONE;
    assign bus.sum  = r_sum;
    assign bus.cout = r_cout;
endmodule

// File: tb/tb_digit_serial_adder.sv
// tb_digit_serial_adder: scoreboard bench for 8-bit and 2-bit digit-serial adder instances
module tb_digit_serial_adder;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   n_pass = 0;
    int   n_total = 0;
    logic [8:0] q8[$];
    logic [2:0] q2[$];

    always #5 clk = ~clk;

    digit_serial_adder_if #(.WIDTH(8)) bus8 ();
    digit_serial_adder_if #(.WIDTH(2)) bus2 ();

    digit_serial_adder #(.WIDTH(8)) u_dut8 (.clk(clk), .rst_n(rst_n), .bus(bus8));
    digit_serial_adder #(.WIDTH(2)) u_dut2 (.clk(clk), .rst_n(rst_n), .bus(bus2));

    task automatic issue8(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a = a;
        bus8.b = b;
        bus8.cin = c;
        q8.push_back({1'b0, a} + {1'b0, b} + 9'(c));
        @(negedge clk);
        bus8.start = 1'b0;
        bus8.a = 8'($urandom);
        bus8.b = 8'($urandom);
        bus8.cin = 1'($urandom);
    endtask

    task automatic issue2(input logic [1:0] a, input logic [1:0] b, input logic c);
        @(negedge clk);
        bus2.start = 1'b1;
        bus2.a = a;
        bus2.b = b;
        bus2.cin = c;
        q2.push_back({1'b0, a} + {1'b0, b} + 3'(c));
        @(negedge clk);
        bus2.start = 1'b0;
        bus2.a = 2'($urandom);
        bus2.b = 2'($urandom);
        bus2.cin = 1'($urandom);
    endtask

    task automatic collect8(output int nbusy, output logic seen, output logic overlap, output logic [8:0] res);
        nbusy = 0;
        seen = 1'b0;
        overlap = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus8.busy && bus8.done) overlap = 1'b1;
            if (bus8.done) seen = 1'b1;
            else begin
                if (bus8.busy) nbusy++;
                @(negedge clk);
            end
        end
        res = {bus8.cout, bus8.sum};
    endtask

    task automatic collect2(output int nbusy, output logic seen, output logic [2:0] res);
        nbusy = 0;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            if (bus2.done) seen = 1'b1;
            else begin
                if (bus2.busy) nbusy++;
                @(negedge clk);
            end
        end
        res = {bus2.cout, bus2.sum};
    endtask

    task automatic test_reset();
        @(negedge clk);
        n_total++;
        if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'd0)
            $display("FAIL reset8 got busy=%b done=%b cout=%b sum=%h want all 0", bus8.busy, bus8.done, bus8.cout, bus8.sum);
        else n_pass++;
        n_total++;
        if ({bus2.busy, bus2.done, bus2.cout, bus2.sum} !== 5'd0)
            $display("FAIL reset2 got busy=%b done=%b cout=%b sum=%b want all 0", bus2.busy, bus2.done, bus2.cout, bus2.sum);
        else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_basic();
        logic [7:0] ta[3] = '{8'h5A, 8'hFF, 8'hFF};
        logic [7:0] tb[3] = '{8'h3C, 8'h01, 8'hFF};
        logic       tc[3] = '{1'b0, 1'b0, 1'b1};
        int nb;
        logic seen, ov;
        logic [8:0] res, exp;
        for (int k = 0; k < 3; k++) begin
            issue8(ta[k], tb[k], tc[k]);
            collect8(nb, seen, ov, res);
            exp = q8.pop_front();
            n_total++;
            if (!seen || nb != 4) $display("FAIL basic_latency[%0d] got done=%b busy_cycles=%0d want done=1 busy_cycles=4", k, seen, nb);
            else n_pass++;
            n_total++;
            if (res !== exp) $display("FAIL basic_sum[%0d] got %h want %h", k, res, exp);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (bus8.done !== 1'b0 || {bus8.cout, bus8.sum} !== exp)
                $display("FAIL basic_hold[%0d] got done=%b res=%h want done=0 res=%h", k, bus8.done, {bus8.cout, bus8.sum}, exp);
            else n_pass++;
        end
    endtask

    task automatic test_width2();
        logic [1:0] ta[2] = '{2'b10, 2'b10};
        logic [1:0] tb[2] = '{2'b00, 2'b11};
        int nb;
        logic seen;
        logic [2:0] res, exp;
        for (int k = 0; k < 2; k++) begin
            issue2(ta[k], tb[k], 1'b1);
            collect2(nb, seen, res);
            exp = q2.pop_front();
            n_total++;
            if (!seen || nb != 1) $display("FAIL w2_latency[%0d] got done=%b busy_cycles=%0d want done=1 busy_cycles=1", k, seen, nb);
            else n_pass++;
            n_total++;
            if (res !== exp) $display("FAIL w2_sum[%0d] got %b want %b", k, res, exp);
            else n_pass++;
        end
    endtask

    task automatic test_back_to_back();
        int nb;
        logic seen, ov;
        logic [8:0] res, exp;
        issue8(8'h21, 8'h43, 1'b0);
        @(negedge clk);
        bus8.start = 1'b1;
        bus8.a = 8'hEE;
        bus8.b = 8'h99;
        @(negedge clk);
        bus8.start = 1'b0;
        collect8(nb, seen, ov, res);
        exp = q8.pop_front();
        n_total++;
        if (!seen || nb != 2) $display("FAIL ignore_latency got done=%b busy_cycles=%0d want done=1 busy_cycles=2", seen, nb);
        else n_pass++;
        n_total++;
        if (res !== exp) $display("FAIL ignore_sum got %h want %h", res, exp);
        else n_pass++;
        bus8.start = 1'b1;
        bus8.a = 8'h12;
        bus8.b = 8'h34;
        bus8.cin = 1'b0;
        q8.push_back(9'h046);
        @(negedge clk);
        bus8.start = 1'b0;
        n_total++;
        if (bus8.busy !== 1'b1 || bus8.done !== 1'b0) $display("FAIL b2b_busy got busy=%b done=%b want busy=1 done=0", bus8.busy, bus8.done);
        else n_pass++;
        collect8(nb, seen, ov, res);
        exp = q8.pop_front();
        n_total++;
        if (!seen || nb != 4 || res !== exp) $display("FAIL b2b_sum got done=%b busy_cycles=%0d res=%h want done=1 busy_cycles=4 res=%h", seen, nb, res, exp);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        int nb;
        int ndone = 0;
        logic seen, ov;
        logic [8:0] res, exp;
        issue8(8'h77, 8'h66, 1'b1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        n_total++;
        if ({bus8.busy, bus8.done, bus8.cout, bus8.sum} !== 11'd0)
            $display("FAIL midreset_clear got busy=%b done=%b cout=%b sum=%h want all 0", bus8.busy, bus8.done, bus8.cout, bus8.sum);
        else n_pass++;
        void'(q8.pop_back());
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus8.done) ndone++;
        end
        n_total++;
        if (ndone != 0) $display("FAIL midreset_nodone got %0d done cycles want 0", ndone);
        else n_pass++;
        issue8(8'h9C, 8'h7B, 1'b1);
        collect8(nb, seen, ov, res);
        exp = q8.pop_front();
        n_total++;
        if (!seen || res !== exp) $display("FAIL midreset_fresh got done=%b res=%h want done=1 res=%h", seen, res, exp);
        else n_pass++;
    endtask

    task automatic test_random();
        int nb;
        logic seen, ov;
        logic [8:0] res, exp;
        for (int k = 0; k < 500; k++) begin
            issue8(8'($urandom), 8'($urandom), 1'($urandom));
            collect8(nb, seen, ov, res);
            exp = q8.pop_front();
            n_total++;
            if (!seen || ov) $display("FAIL rand_done[%0d] got done=%b overlap=%b want done=1 overlap=0", k, seen, ov);
            else n_pass++;
            n_total++;
            if (res !== exp) $display("FAIL rand_sum[%0d] got %h want %h", k, res, exp);
            else n_pass++;
            @(negedge clk);
            n_total++;
            if (bus8.done !== 1'b0 || bus8.busy !== 1'b0) $display("FAIL rand_pulse[%0d] got done=%b busy=%b want 0 0", k, bus8.done, bus8.busy);
            else n_pass++;
        end
    endtask

    initial begin
        bus8.start = 1'b0;
        bus8.a = '0;
        bus8.b = '0;
        bus8.cin = 1'b0;
        bus2.start = 1'b0;
        bus2.a = '0;
        bus2.b = '0;
        bus2.cin = 1'b0;
        test_reset();
        test_basic();
        test_width2();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
